// File: rtl/antitheft_pkg.sv
// antitheft_pkg: shared interval codes, default time parameters and the
// timer state encoding for the anti-theft interval timer.
package antitheft_pkg;

   // Interval / parameter select codes
   localparam logic [1:0] INT_ARM_DELAY       = 2'b00;
   localparam logic [1:0] INT_DRIVER_DELAY    = 2'b01;
   localparam logic [1:0] INT_PASSENGER_DELAY = 2'b10;
   localparam logic [1:0] INT_ALARM_ON        = 2'b11;

   // Power-up values of the reprogrammable time parameters (seconds)
   localparam logic [3:0] T_ARM_DELAY_DEF       = 4'd6;
   localparam logic [3:0] T_DRIVER_DELAY_DEF    = 4'd8;
   localparam logic [3:0] T_PASSENGER_DELAY_DEF = 4'd15;
   localparam logic [3:0] T_ALARM_ON_DEF        = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } timer_state_e;

   // Reset value of the parameter selected by an interval code
   function automatic logic [3:0] default_param(input logic [1:0] code);
      logic [3:0] value_s;
      case (code)
         INT_ARM_DELAY:       value_s = T_ARM_DELAY_DEF;
         INT_DRIVER_DELAY:    value_s = T_DRIVER_DELAY_DEF;
         INT_PASSENGER_DELAY: value_s = T_PASSENGER_DELAY_DEF;
         INT_ALARM_ON:        value_s = T_ALARM_ON_DEF;
         default:             value_s = T_ARM_DELAY_DEF;
      endcase
      return value_s;
   endfunction

endpackage

// File: rtl/antitheft_timer_if.sv
// antitheft_timer_if: controller <-> timer handshake, parameter write port
// and 1 Hz strobe. The time_left display bus exists only when
// TIMER_TIME_LEFT_EN is defined.
interface antitheft_timer_if;

   logic       start_timer;
   logic [1:0] interval;
   logic       reprogram;
   logic [1:0] time_param_sel;
   logic [3:0] time_value;
   logic       expired;
   logic       one_hz_enable;
`ifdef TIMER_TIME_LEFT_EN
   logic [3:0] time_left;

   modport master (
      output start_timer, interval, reprogram, time_param_sel, time_value,
      input  expired, one_hz_enable, time_left
   );

   modport slave (
      input  start_timer, interval, reprogram, time_param_sel, time_value,
      output expired, one_hz_enable, time_left
   );
`else
   modport master (
      output start_timer, interval, reprogram, time_param_sel, time_value,
      input  expired, one_hz_enable
   );

   modport slave (
      input  start_timer, interval, reprogram, time_param_sel, time_value,
      output expired, one_hz_enable
   );
`endif

endinterface

// File: rtl/one_hz_prescaler.sv
// one_hz_prescaler: free-running 0..CLK_HZ-1 counter producing a one-cycle
// tick while the count sits at CLK_HZ-1. 'clear' restarts the count at 0.
module one_hz_prescaler #(
   parameter int CLK_HZ = 100_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int              PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0]   LAST = PW'(CLK_HZ - 1);

   logic [PW-1:0] cnt_r;
   logic [PW-1:0] cnt_s;
   logic          tick_r;

   // Next prescaler value: clear wins, otherwise count and wrap at LAST
   always_comb begin
      cnt_s = cnt_r;
      if (clear) begin
         cnt_s = {PW{1'b0}};
      end else if (cnt_r == LAST) begin
         cnt_s = {PW{1'b0}};
      end else begin
         cnt_s = cnt_r + PW'(1);
      end
   end

   // Count register; tick is registered so it is high exactly while cnt_r == LAST
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_r  <= {PW{1'b0}};
         tick_r <= 1'b0;
      end else begin
         cnt_r  <= cnt_s;
         tick_r <= (cnt_s == LAST);
      end
   end

   assign tick = tick_r;

endmodule

// File: rtl/antitheft_timer.sv
// antitheft_timer: four reprogrammable second parameters, a countdown of
// the parameter selected by 'interval' while 'start_timer' is held, a
// one-cycle 'expired' pulse, and the system 1 Hz enable strobe.
// Optional: TIMER_TIME_LEFT_EN adds the time_left countdown display output.
module antitheft_timer
   import antitheft_pkg::*;
#(
   parameter int CLK_HZ = 100_000_000
) (
   input  logic            clock,
   input  logic            reset,
   antitheft_timer_if.slave tif
);

   timer_state_e state_r;
   timer_state_e state_s;
   logic [3:0]   count_r;
   logic [3:0]   count_s;
   logic [1:0]   int_q_r;
   logic [1:0]   int_s;
   logic [3:0]   param_r [4];
   logic [3:0]   load_val_s;
   logic         load_s;
   logic         expire_s;
   logic         expired_r;
   logic         tick_s;

   one_hz_prescaler #(
      .CLK_HZ (CLK_HZ)
   ) u_prescaler (
      .clock (clock),
      .reset (reset),
      .clear (load_s),
      .tick  (tick_s)
   );

   assign load_val_s = param_r[tif.interval];

   // Next-state, count and expiry decision; reprogram has top priority in every state
   always_comb begin
      state_s  = state_r;
      count_s  = count_r;
      int_s    = int_q_r;
      load_s   = 1'b0;
      expire_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (tif.start_timer && !tif.reprogram) begin
               load_s  = 1'b1;
               state_s = ST_RUN;
               count_s = load_val_s;
               int_s   = tif.interval;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (tif.reprogram) begin
               state_s = ST_IDLE;
            end else if (!tif.start_timer) begin
               state_s = ST_IDLE;
            end else if (tif.interval != int_q_r) begin
               load_s  = 1'b1;
               state_s = ST_RUN;
               count_s = load_val_s;
               int_s   = tif.interval;
            end else if (count_r == 4'd0) begin
               expire_s = 1'b1;
               state_s  = ST_DONE;
            end else if (tick_s) begin
               if (count_r == 4'd1) begin
                  count_s  = 4'd0;
                  expire_s = 1'b1;
                  state_s  = ST_DONE;
               end else begin
                  count_s = count_r - 4'd1;
               end
            end else begin
               count_s = count_r;
            end
         end
         ST_DONE: begin
            // Interval change while start stays high chains straight into a new count
            if (tif.reprogram || !tif.start_timer) begin
               state_s = ST_IDLE;
            end else if (tif.interval != int_q_r) begin
               load_s  = 1'b1;
               state_s = ST_RUN;
               count_s = load_val_s;
               int_s   = tif.interval;
            end else begin
               state_s = ST_DONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // FSM, count, latched interval and the registered expiry pulse
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         count_r   <= 4'd0;
         int_q_r   <= 2'b00;
         expired_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         count_r   <= count_s;
         int_q_r   <= int_s;
         expired_r <= expire_s;
      end
   end

   // Parameter register file; writes affect only the next load
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            param_r[i] <= default_param(2'(i));
         end
      end else if (tif.reprogram) begin
         param_r[tif.time_param_sel] <= tif.time_value;
      end else begin
         param_r <= param_r;
      end
   end

   assign tif.expired       = expired_r;
   assign tif.one_hz_enable = tick_s;

`ifdef TIMER_TIME_LEFT_EN
   logic [3:0] time_left_r;

   // Display value: the running count, zero outside RUN
   always_ff @(posedge clock) begin
      if (reset) begin
         time_left_r <= 4'd0;
      end else if (state_s == ST_RUN) begin
         time_left_r <= count_s;
      end else begin
         time_left_r <= 4'd0;
      end
   end

   assign tif.time_left = time_left_r;
`endif

endmodule

// File: tb/tb_antitheft_timer.sv
// tb_antitheft_timer: directed scenarios plus biased random stimulus, every
// cycle compared against a reference model that works in elapsed cycles
// since the last load rather than in counters.
module tb_antitheft_timer;

   localparam int CLK = 4;

   logic clock;
   logic reset;

   antitheft_timer_if tif ();

   antitheft_timer #(
      .CLK_HZ (CLK)
   ) dut (
      .clock (clock),
      .reset (reset),
      .tif   (tif)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks;
   int failures;
   int e;            // index of the next rising edge
   int m_mode;       // 0 idle, 1 counting, 2 expired/holding
   int m_e0;         // edge of the last load
   int m_n;          // seconds loaded
   int m_int;        // interval loaded
   int m_base;       // edge at which the 1 Hz phase last restarted
   int params [4];
   int exp_expired;
   int exp_enable;
   int exp_tl;
   int seen_exp;
   int model_exp;

   task automatic check_eq(input string tag, input int obs, input int exp_v);
      checks++;
      if (obs != exp_v) begin
         failures++;
         $display("FAIL %s edge=%0d got=%0d want=%0d", tag, e, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      m_mode    = 0;
      m_int     = 0;
      m_n       = 0;
      m_e0      = e;
      params[0] = 6;
      params[1] = 8;
      params[2] = 15;
      params[3] = 10;
      m_base    = e;
      exp_expired = 0;
      exp_enable  = 0;
      exp_tl      = 0;
      e++;
   endtask

   task automatic model_step(input int st, input int iv, input int rp, input int sel, input int val);
      int ld;
      int nxt;
      ld  = 0;
      nxt = 0;
      case (m_mode)
         0: if (st != 0 && rp == 0) ld = 1;
         1: begin
            if (rp != 0 || st == 0) m_mode = 0;
            else if (iv != m_int) ld = 1;
            else if (m_n == 0 || (e - m_e0) == m_n * CLK) begin
               m_mode = 2;
               nxt    = 1;
            end
         end
         2: begin
            if (rp != 0 || st == 0) m_mode = 0;
            else if (iv != m_int) ld = 1;
         end
         default: m_mode = 0;
      endcase
      if (rp != 0) params[sel] = val;
      if (ld != 0) begin
         m_mode = 1;
         m_e0   = e;
         m_n    = params[iv];
         m_int  = iv;
         m_base = e;
      end
      exp_expired = nxt;
      exp_enable  = (((e - m_base) % CLK) == CLK - 1) ? 1 : 0;
      exp_tl      = (m_mode == 1) ? (m_n - (e - m_e0) / CLK) : 0;
      model_exp  += nxt;
      e++;
   endtask

   // One clock: check outputs of the previous edge, then drive this cycle's inputs
   task automatic cycle(input logic st, input logic [1:0] iv, input logic rp,
                        input logic [1:0] sel, input logic [3:0] val);
      @(negedge clock);
      check_eq("expired", int'(tif.expired), exp_expired);
      check_eq("one_hz_enable", int'(tif.one_hz_enable), exp_enable);
`ifdef TIMER_TIME_LEFT_EN
      check_eq("time_left", int'(tif.time_left), exp_tl);
`endif
      if (tif.expired === 1'b1) seen_exp++;
      reset              = 1'b0;
      tif.start_timer    = st;
      tif.interval       = iv;
      tif.reprogram      = rp;
      tif.time_param_sel = sel;
      tif.time_value     = val;
      model_step(int'(st), int'(iv), int'(rp), int'(sel), int'(val));
   endtask

   task automatic hold(input int n, input logic st, input logic [1:0] iv);
      for (int i = 0; i < n; i++) cycle(st, iv, 1'b0, 2'b00, 4'd0);
   endtask

   initial begin
      logic       cur_st;
      logic [1:0] cur_iv;
      logic       rp;
      logic [1:0] sel;
      logic [3:0] val;
      checks    = 0;
      failures  = 0;
      e         = 0;
      seen_exp  = 0;
      model_exp = 0;
      reset              = 1'b1;
      tif.start_timer    = 1'b0;
      tif.interval       = 2'b00;
      tif.reprogram      = 1'b0;
      tif.time_param_sel = 2'b00;
      tif.time_value     = 4'd0;
      @(negedge clock);
      model_reset();
      @(negedge clock);
      model_reset();

      // Arm delay with default 6 s: expiry 24 cycles after the load
      hold(30, 1'b1, 2'b00);
      hold(2, 1'b0, 2'b00);
      // Driver delay, then switch to alarm-on with start held
      hold(40, 1'b1, 2'b01);
      hold(50, 1'b1, 2'b11);
      hold(2, 1'b0, 2'b00);
      // Reprogram passenger delay to 3 s
      cycle(1'b0, 2'b00, 1'b1, 2'b10, 4'd3);
      hold(16, 1'b1, 2'b10);
      hold(2, 1'b0, 2'b00);
      // Zero-second parameter
      cycle(1'b0, 2'b00, 1'b1, 2'b00, 4'd0);
      hold(4, 1'b1, 2'b00);
      hold(2, 1'b0, 2'b00);
      cycle(1'b0, 2'b00, 1'b1, 2'b00, 4'd6);
      // Abort at cycle 10, then restart
      hold(11, 1'b1, 2'b00);
      hold(1, 1'b0, 2'b00);
      hold(30, 1'b1, 2'b00);
      hold(2, 1'b0, 2'b00);
      // Reprogram on the edge the count would hit zero
      hold(32, 1'b1, 2'b01);
      cycle(1'b1, 2'b01, 1'b1, 2'b01, 4'd8);
      hold(4, 1'b1, 2'b01);
      hold(2, 1'b0, 2'b00);

      // Biased random traffic
      cur_st = 1'b0;
      cur_iv = 2'b00;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 59) == 0) cur_st = ~cur_st;
         if ($urandom_range(0, 79) == 0) cur_iv = 2'($urandom_range(0, 3));
         rp  = ($urandom_range(0, 69) == 0);
         sel = 2'($urandom_range(0, 3));
         val = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         cycle(cur_st, cur_iv, rp, sel, val);
      end
      hold(1, 1'b0, 2'b00);

      check_eq("expired_pulse_count", seen_exp, model_exp);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
